// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
// Contents: funct3 op encoding, FSM state encoding, iteration count and
// a two's-complement magnitude helper.
package muldiv_pkg;

    localparam int unsigned MD_XLEN  = 32;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = 6;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Magnitude of x when it is interpreted as signed; passthrough otherwise.
    function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] x,
                                                  input logic               is_signed);
        return (is_signed && x[MD_XLEN-1]) ? (~x + MD_XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Ports:
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc      - {upper, lower} accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, dividend/quotient}.
//   operand  - multiplicand (multiply) or divisor (divide) magnitude
//   acc_next - accumulator after this step
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int unsigned W = MD_XLEN
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        // Multiply: conditional add into the upper half, keep carry for the shift.
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : (W+1)'(0));
        // Divide: remainder shifted left with the next dividend bit, then trial subtract.
        shifted = acc[2*W-1:W-1];
        diff    = shifted - {1'b0, operand};

        if (is_div) begin
            if (diff[W]) begin
                acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
            end else begin
                acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Ports:
//   i_clk, i_rst_n           - clock (rising edge), async active-low reset
//   i_start, i_op            - start request and RV32M funct3, sampled in IDLE
//   i_operand_a/b            - rs1/rs2 data
//   i_flush                  - kill any in-flight op
//   o_busy                   - combinational stall request
//   o_valid                  - one-cycle result strobe
//   o_result                 - registered result, held until the next write
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned W  = XLEN;
    localparam int unsigned DW = 2 * XLEN;
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    md_state_e             state_q, state_n;
    md_op_e                op_q;
    logic                  is_div_q;
    logic                  a_neg_q, b_neg_q;
    logic [DW-1:0]         acc_q, acc_next;
    logic [W-1:0]          opnd_q;
    logic [MD_CNT_W-1:0]   cnt_q;
    logic                  spec_q;
    logic [W-1:0]          spec_val_q;
    logic [W-1:0]          result_q;
    logic                  valid_q;

    logic                  accept, calc_en, fix_en;
    logic                  a_signed, b_signed, is_div_in;
    logic [W-1:0]          mag_a, mag_b;
    logic                  div_zero, div_ovf, special_in;
    logic [W-1:0]          spec_val_in;
    logic [DW-1:0]         prod_fix;
    logic [W-1:0]          quot_fix, rem_fix, fix_val;

    // Operand decode for a new request: signedness, magnitudes, special cases
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md_op_e'(i_op))
            MD_MULH, MD_DIV, MD_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        is_div_in  = i_op[2];
        mag_a      = md_abs(i_operand_a, a_signed);
        mag_b      = md_abs(i_operand_b, b_signed);
        div_zero   = is_div_in && (i_operand_b == '0);
        div_ovf    = is_div_in && b_signed && (i_operand_a == INT_MIN) && (i_operand_b == '1);
        special_in = div_zero | div_ovf;
        // funct3 bit 1 separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            spec_val_in = i_op[1] ? i_operand_a : '1;
        end else begin
            spec_val_in = i_op[1] ? '0 : INT_MIN;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next state; flush overrides everything
    always_comb begin
        state_n = state_q;
        if (i_flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_n = (EARLY_OUT && special_in) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == MD_CNT_W'(MD_ITER - 1)) begin
                        state_n = ST_FIX;
                    end
                end
                ST_FIX:  state_n = ST_DONE;
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // FSM outputs / datapath enables
    always_comb begin
        accept  = 1'b0;
        calc_en = 1'b0;
        fix_en  = 1'b0;
        o_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = i_start & ~i_flush;
                o_busy = i_start & ~i_flush;
            end
            ST_CALC: begin
                calc_en = ~i_flush;
                o_busy  = 1'b1;
            end
            ST_FIX: begin
                fix_en = ~i_flush;
                o_busy = 1'b1;
            end
            default: ;
        endcase
    end

    muldiv_core #(.W(W)) u_core (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_next)
    );

    // Sign correction and result selection
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + DW'(1)) : acc_q;
        quot_fix = (a_neg_q ^ b_neg_q) ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
        rem_fix  = a_neg_q ? (~acc_q[DW-1:W] + W'(1)) : acc_q[DW-1:W];
        case (op_q)
            MD_MUL:                        fix_val = prod_fix[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_val = prod_fix[DW-1:W];
            MD_DIV, MD_DIVU:               fix_val = quot_fix;
            default:                       fix_val = rem_fix;
        endcase
        if (spec_q) begin
            fix_val = spec_val_q;
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q       <= MD_MUL;
            is_div_q   <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
        end else if (accept) begin
            op_q       <= md_op_e'(i_op);
            is_div_q   <= is_div_in;
            a_neg_q    <= a_signed & i_operand_a[W-1];
            b_neg_q    <= b_signed & i_operand_b[W-1];
            acc_q      <= is_div_in ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
            opnd_q     <= is_div_in ? mag_b : mag_a;
            cnt_q      <= '0;
            spec_q     <= special_in;
            spec_val_q <= spec_val_in;
        end else if (calc_en) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + MD_CNT_W'(1);
        end
    end

    // Result and valid strobe registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (accept && EARLY_OUT && special_in) begin
                result_q <= spec_val_in;
            end else if (fix_en) begin
                result_q <= fix_val;
            end
            valid_q <= (state_n == ST_DONE);
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: one early-out instance and one
// full-latency instance share the same stimulus.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        spec;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;

    logic        busy_f, valid_f, busy_s, valid_s;
    logic [31:0] res_f, res_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
        .o_busy(busy_f), .o_valid(valid_f), .o_result(res_f)
    );

    muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b0)) dut_slow (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
        .o_busy(busy_s), .o_valid(valid_s), .o_result(res_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to the next cycle's sampling point, optionally updating inputs between.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and watch both instances for 37 cycles.
    task automatic run_vec(input logic [2:0] vop, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vexp, input logic vspec, input string name);
        int lat_f, seen_f, seen_s, cnt_f, cnt_s, bb_f, bb_s;
        logic [31:0] r_f, r_s;
        lat_f  = vspec ? 1 : 34;
        seen_f = -1; seen_s = -1; cnt_f = 0; cnt_s = 0; bb_f = 0; bb_s = 0;
        r_f = 32'd0; r_s = 32'd0;
        op = vop; a = va; b = vb; start = 1'b1;
        for (int cyc = 0; cyc <= 36; cyc++) begin
            if (cyc > 0) begin
                next_cycle();
                start = 1'b0;
            end
            #1;
            if (busy_f !== (cyc < lat_f)) bb_f++;
            if (busy_s !== (cyc < 34))    bb_s++;
            if (valid_f === 1'b1) begin
                cnt_f++;
                if (seen_f < 0) begin seen_f = cyc; r_f = res_f; end
            end
            if (valid_s === 1'b1) begin
                cnt_s++;
                if (seen_s < 0) begin seen_s = cyc; r_s = res_s; end
            end
        end
        check({name, " fast result"},      r_f, vexp);
        check({name, " fast valid cycle"}, 32'(seen_f), 32'(lat_f));
        check({name, " fast valid count"}, 32'(cnt_f), 32'd1);
        check({name, " fast busy errors"}, 32'(bb_f), 32'd0);
        check({name, " slow result"},      r_s, vexp);
        check({name, " slow valid cycle"}, 32'(seen_s), 32'd34);
        check({name, " slow valid count"}, 32'(cnt_s), 32'd1);
        check({name, " slow busy errors"}, 32'(bb_s), 32'd0);
    endtask

    initial begin
        vec_t        vecs[18];
        logic [31:0] prev_f, prev_s;
        int          vcnt, seen_f, seen_s, cnt_f, cnt_s, bad;
        logic [31:0] r_f, r_s;

        vecs[0]  = '{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{MD_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
        vecs[2]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[3]  = '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[4]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[5]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
        vecs[9]  = '{MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0};
        vecs[10] = '{MD_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{MD_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[12] = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[13] = '{MD_REMU,   32'd5,        32'd0,        32'd5,        1'b1};
        vecs[14] = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
        vecs[16] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[17] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("reset busy fast",   32'(busy_f),  32'd0);
        check("reset valid fast",  32'(valid_f), 32'd0);
        check("reset result fast", res_f,        32'd0);
        check("reset result slow", res_s,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].spec,
                    $sformatf("vec%0d", i));
        end

        // Flush mid-divide in cycle 10, restart in cycle 11, ignored start in cycle 20
        prev_f = res_f; prev_s = res_s;
        op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        vcnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            next_cycle();
            start = 1'b0;
            if (cyc == 10) flush = 1'b1;
            #1;
            if (valid_f === 1'b1 || valid_s === 1'b1) vcnt++;
        end
        next_cycle();
        flush = 1'b0;
        #1;
        if (valid_f === 1'b1 || valid_s === 1'b1) vcnt++;
        check("flush no valid",        32'(vcnt),   32'd0);
        check("flush idle busy fast",  32'(busy_f), 32'd0);
        check("flush idle busy slow",  32'(busy_s), 32'd0);
        check("flush result hold fast", res_f, prev_f);
        check("flush result hold slow", res_s, prev_s);

        op = MD_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
        #1;
        check("restart busy cycle 11", 32'(busy_f), 32'd1);
        seen_f = -1; seen_s = -1; cnt_f = 0; cnt_s = 0; r_f = 32'd0; r_s = 32'd0;
        for (int cyc = 12; cyc <= 50; cyc++) begin
            next_cycle();
            start = (cyc == 20);
            if (cyc == 20) begin op = MD_DIVU; a = 32'd9; b = 32'd3; end
            #1;
            if (valid_f === 1'b1) begin cnt_f++; if (seen_f < 0) begin seen_f = cyc; r_f = res_f; end end
            if (valid_s === 1'b1) begin cnt_s++; if (seen_s < 0) begin seen_s = cyc; r_s = res_s; end end
        end
        check("restart valid cycle fast", 32'(seen_f), 32'd45);
        check("restart valid cycle slow", 32'(seen_s), 32'd45);
        check("restart result fast", r_f, 32'd12);
        check("restart result slow", r_s, 32'd12);
        check("restart valid count fast", 32'(cnt_f), 32'd1);
        check("restart valid count slow", 32'(cnt_s), 32'd1);
        check("ignored start result hold", res_f, 32'd12);

        // Flush and start together: nothing starts
        op = MD_DIV; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        check("flush+start busy fast", 32'(busy_f), 32'd0);
        check("flush+start busy slow", 32'(busy_s), 32'd0);
        bad = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            next_cycle();
            start = 1'b0; flush = 1'b0;
            #1;
            if (valid_f !== 1'b0 || valid_s !== 1'b0 || busy_f !== 1'b0 || busy_s !== 1'b0) bad++;
        end
        check("flush+start dropped", 32'(bad), 32'd0);
        check("flush+start result hold", res_s, 32'd12);

        // Asynchronous reset in the middle of CALC
        op = MD_MUL; a = 32'h00001234; b = 32'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            next_cycle();
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy fast",   32'(busy_f),  32'd0);
        check("async reset busy slow",   32'(busy_s),  32'd0);
        check("async reset valid slow",  32'(valid_s), 32'd0);
        check("async reset result fast", res_f,        32'd0);
        check("async reset result slow", res_s,        32'd0);
        #2 rst_n = 1'b1;
        next_cycle();
        run_vec(MD_MUL, 32'd2, 32'd2, 32'd4, 1'b0, "post-reset mul");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits in the EX stage beside the ALU.
- Accepts one M-extension operation from ID/EX and runs a 32-step shift-add multiplier or restoring divider over an internal datapath.
- Stalls the pipeline via o_busy while computing, then presents the result for one cycle so EX/MEM can capture it.
- All 8 RV32M ops are covered; single-cycle ALU ops never enter this block.

Parameters:
- XLEN, 32: operand/result width. Only 32 is supported.
- EARLY_OUT, 1: when 1, divide-by-zero and signed-overflow divide skip iteration (1-cycle latency). When 0, they take the full 34-cycle path with the same result.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  in  32  rs1 data (already forwarded).
- i_operand_b  in  32  rs2 data (already forwarded).
- i_flush  in  1  kill the in-flight op (branch mispredict/redirect).
- o_busy  out  1  stall request to hazard unit.
- o_valid  out  1  result valid, one-cycle pulse.
- o_result  out  32  registered result.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (i_rst_n). Reset forces state=IDLE, o_valid=0, o_result=0, counter=0 immediately, including mid-operation.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE & i_start & !i_flush:
  - Latch op, sign flags and operand magnitudes. MULH and DIV/REM treat both operands as signed; MULHSU treats a as signed, b as unsigned.
  - Clear the 6-bit counter.
  - Next state is CALC, or DONE if EARLY_OUT and a special case applies.
- CALC: one iteration per cycle, counter 0..31; after the 32nd iteration, go to FIX.
  - Multiply: 64-bit accumulator; add multiplicand if the current multiplier LSB is 1, then shift right 1.
  - Divide: 33-bit partial remainder; shift left bringing in the next dividend bit, trial-subtract the divisor, set the quotient bit if the result is non-negative, restore otherwise.
- FIX: apply sign correction, select the output, register it into o_result; go to DONE.
  - Negate the 64-bit product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV).
  - The remainder takes the dividend's sign (REM).
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DONE: o_valid=1 for exactly this cycle; go to IDLE.
- Latency: start accepted in cycle 0, CALC in cycles 1-32, FIX in cycle 33, o_valid in cycle 34. Early-out: o_valid in cycle 1.
- o_busy = (state==CALC || state==FIX) || (state==IDLE && i_start && !i_flush).
  - This is combinational, so the stall asserts in the start cycle.
  - o_busy is low in DONE, so the pipeline advances while capturing o_result.
- o_result holds its value after DONE until the next result is written. o_valid is 0 outside DONE.
- Special cases (EARLY_OUT=1 or 0, same values):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
- i_start in any state other than IDLE is ignored.
- i_flush in any state: next state IDLE, no o_valid, o_result unchanged. Flush and start in the same cycle: flush wins, op dropped.
- i_flush in DONE does not retract the o_valid pulse already being driven.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum for funct3 ops (MD_MUL..MD_REMU);
  - typedef enum for FSM state;
  - constant MD_ITER=32;
  - helper function for 2's-complement absolute value.
- One sub-module, muldiv_core: the per-iteration shift-add/trial-subtract datapath step. It is purely combinational and instantiated once, selected by an is_div flag.
- The FSM, counter and sign-fix logic stay in muldiv_seq.

Test Plan:
1. MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB; o_busy high cycles 0-33; o_valid only in cycle 34.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
4. Special cases: DIV 5 / 0 -> 0xFFFFFFFF with o_valid in cycle 1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. Repeat all with EARLY_OUT=0 -> same values at cycle 34.
5. Flush and start handling:
   - Start DIVU, then i_flush in cycle 10 -> no o_valid, state IDLE in cycle 11.
   - Start MUL 3 x 4 in cycle 11 -> 12 in cycle 45.
   - An i_start pulsed in cycle 20 is ignored.
   - Flush and start together -> nothing starts.
6. Assert i_rst_n=0 asynchronously mid-CALC (cycle 15) -> o_busy, o_valid and o_result go to 0 before the next edge. After release, a MUL 2 x 2 start returns 4 at +34.
